// File: rtl/spi_gain_writer.sv
// SPI mode-0 slave that programs and reads back the ten 13-bit equalizer band gains.
// SPI pins are oversampled in the clk domain; gains only change on frame commit.
module spi_gain_writer #(
    parameter logic [12:0] GAIN_RESET = 13'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [12:0] gain_1,
    output logic [12:0] gain_2,
    output logic [12:0] gain_3,
    output logic [12:0] gain_4,
    output logic [12:0] gain_5,
    output logic [12:0] gain_6,
    output logic [12:0] gain_7,
    output logic [12:0] gain_8,
    output logic [12:0] gain_9,
    output logic [12:0] gain_10,
    output logic        wr_stb,
    output logic [3:0]  wr_addr,
    output logic        frame_err
);

    localparam logic [4:0] FRAME_BITS = 5'd24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        sclk_meta_r, sclk_sync_r, sclk_hist_r;
    logic        cs_meta_r, cs_sync_r, cs_hist_r;
    logic        mosi_meta_r, mosi_sync_r;
    logic [23:0] sh_r, sh_nxt_s;
    logic [4:0]  bit_cnt_r, cnt_inc_s;
    logic [12:0] rd_sh_r, rd_word_s;
    logic [3:0]  rd_addr_s, cmd_addr_s;
    logic [12:0] gain_r [10];
    logic        miso_r, wr_stb_r, frame_err_r;
    logic [3:0]  wr_addr_r;
    logic        sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
    logic        shift_s, clear_s, commit_s, rd_latch_s, do_write_s, do_err_s;

    // Pin synchronisers; cs resets to "active" so a frame already running at reset release is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_hist_r <= 1'b0;
            cs_meta_r   <= 1'b0;
            cs_sync_r   <= 1'b0;
            cs_hist_r   <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= spi_sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_hist_r <= sclk_sync_r;
            cs_meta_r   <= spi_cs_n;
            cs_sync_r   <= cs_meta_r;
            cs_hist_r   <= cs_sync_r;
            mosi_meta_r <= spi_mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign sclk_rise_s = sclk_sync_r & ~sclk_hist_r;
    assign sclk_fall_s = ~sclk_sync_r & sclk_hist_r;
    assign cs_fall_s   = ~cs_sync_r & cs_hist_r;
    assign cs_rise_s   = cs_sync_r & ~cs_hist_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control; an SCLK edge coinciding with cs rise is still shifted
    always_comb begin
        state_nxt_s = state_r;
        shift_s     = 1'b0;
        clear_s     = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    clear_s     = 1'b1;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = sclk_rise_s;
                if (cs_rise_s) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            COMMIT: begin
                commit_s    = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath helpers: next shift value, saturating count, read-data select
    always_comb begin
        sh_nxt_s   = {sh_r[22:0], mosi_sync_r};
        cnt_inc_s  = (bit_cnt_r == 5'd31) ? 5'd31 : bit_cnt_r + 5'd1;
        rd_latch_s = shift_s && (bit_cnt_r == 5'd10);
        rd_addr_s  = sh_nxt_s[9:6];
        rd_word_s  = 13'd0;
        for (int i = 0; i < 10; i++) begin
            rd_word_s = (rd_addr_s == 4'(i)) ? gain_r[i] : rd_word_s;
        end
        cmd_addr_s = sh_r[22:19];
        do_write_s = commit_s && (bit_cnt_r == FRAME_BITS) && !sh_r[23] && (cmd_addr_s <= 4'd9);
        do_err_s   = commit_s && (bit_cnt_r != FRAME_BITS);
    end

    // Frame shift register and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r      <= 24'd0;
            bit_cnt_r <= 5'd0;
        end else if (clear_s) begin
            sh_r      <= 24'd0;
            bit_cnt_r <= 5'd0;
        end else if (shift_s) begin
            sh_r      <= sh_nxt_s;
            bit_cnt_r <= cnt_inc_s;
        end
    end

    // Read shifter and MISO: read word latched after the 11th bit, one bit per falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sh_r <= 13'd0;
            miso_r  <= 1'b0;
        end else begin
            if (clear_s) begin
                rd_sh_r <= 13'd0;
            end else if (rd_latch_s) begin
                rd_sh_r <= rd_word_s;
            end else if (state_r == SHIFT && sclk_fall_s && bit_cnt_r >= 5'd11 && bit_cnt_r <= 5'd23) begin
                rd_sh_r <= {rd_sh_r[11:0], 1'b0};
            end
            if (state_r != SHIFT || cs_sync_r) begin
                miso_r <= 1'b0;
            end else if (sclk_fall_s) begin
                miso_r <= (bit_cnt_r >= 5'd11 && bit_cnt_r <= 5'd23) ? rd_sh_r[12] : 1'b0;
            end
        end
    end

    // Gain bank: only the COMMIT of a complete write frame may change a register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                gain_r[i] <= GAIN_RESET;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (do_write_s && cmd_addr_s == 4'(i)) begin
                    gain_r[i] <= sh_r[12:0];
                end
            end
        end
    end

    // Commit strobes and last-write address
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_stb_r    <= 1'b0;
            frame_err_r <= 1'b0;
            wr_addr_r   <= 4'd0;
        end else begin
            wr_stb_r    <= do_write_s;
            frame_err_r <= do_err_s;
            if (do_write_s) begin
                wr_addr_r <= cmd_addr_s;
            end
        end
    end

    assign spi_miso  = miso_r;
    assign wr_stb    = wr_stb_r;
    assign frame_err = frame_err_r;
    assign wr_addr   = wr_addr_r;
    assign gain_1    = gain_r[0];
    assign gain_2    = gain_r[1];
    assign gain_3    = gain_r[2];
    assign gain_4    = gain_r[3];
    assign gain_5    = gain_r[4];
    assign gain_6    = gain_r[5];
    assign gain_7    = gain_r[6];
    assign gain_8    = gain_r[7];
    assign gain_9    = gain_r[8];
    assign gain_10   = gain_r[9];

endmodule

// File: doc/spi_gain_writer.md
Name: spi_gain_writer

Overview:
SPI-slave configuration port that writes and reads back the ten 13-bit band-gain registers consumed by the equalizer.
- It is the write side of the gain register bank. The equalizer multiplies each band's filter output by these gains.
- It takes over the role of the static register map, so the band gains become host-programmable at run time.
- All SPI pins are asynchronous to clk. They are oversampled and edge-detected in the clk domain.

Parameters:
GAIN_RESET, 13'd4096, reset value loaded into every gain register
FRAME_BITS, 24, SPI frame length in bits; fixed, not user-changeable

Ports:
clk  input  1  system clock; must be ≥ 8× SPI SCLK frequency
rst  input  1  synchronous active-high reset
spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_cs_n  input  1  SPI chip select, active low
spi_mosi  input  1  SPI data from host, MSB first
spi_miso  output  1  SPI data to host
gain_1 .. gain_10  output  13 each  band gain registers; gain_1 = low-pass band … gain_10 = high-pass band
wr_stb  output  1  one-clk pulse when a gain register is written
wr_addr  output  4  address of the last write (0..9); valid while wr_stb is high, holds otherwise
frame_err  output  1  one-clk pulse when a frame is discarded

Behaviour:
- Synchronisation:
  - spi_sclk, spi_cs_n and spi_mosi each pass through a 2-FF synchroniser, plus one history FF for edge detection.
  - cs_n is treated as active when the synchronised value is 0.
- Frame format, MSB first, 24 bits:
  - [23] rw: 0 = write, 1 = read.
  - [22:19] addr: 0..9 selects gain_1..gain_10.
  - [18:13] reserved: ignored on write.
  - [12:0] data.
- FSM states:
  - IDLE: on cs_n falling edge, clear the bit counter and the shift register, then go to SHIFT.
  - SHIFT:
    - On each SCLK rising edge, shift mosi into sh[23:0] and increment bit_cnt (5 bits, saturating at 31).
    - When bit_cnt reaches 11, latch the read data. It is gain[addr] if addr ≤ 9, otherwise 13'd0.
    - On cs_n rising edge, go to COMMIT.
  - COMMIT (1 clk), then return to IDLE:
    - If bit_cnt == 24 and rw == 0 and addr ≤ 9: write gain[addr] <= sh[12:0]; pulse wr_stb; update wr_addr.
    - If bit_cnt != 24: pulse frame_err; no register changes.
    - If bit_cnt == 24 and (rw == 1 or addr > 9): no register change and no pulses.
- MISO:
  - Driven 0 in IDLE and for bits 23..13 of the frame.
  - On the first SCLK falling edge after the 11th rising edge, present read bit 12.
  - Shift one bit per subsequent falling edge, down to bit 0.
  - Forced to 0 when cs_n is inactive.
- Latency: a gain output changes exactly 4 clk rising edges after the spi_cs_n pin rises (2 sync + 1 detect + 1 COMMIT).
- Gains are held stable at all other times. Gains never change mid-frame, so the equalizer never sees a partially written value.
- Simultaneous events:
  - If cs_n rises on the same clk in which an SCLK rising edge is detected, the bit is shifted first, then COMMIT is evaluated with the updated count.
  - SCLK edges while cs_n is inactive are ignored.
- Over-length frame (more than 24 bits): bit_cnt saturates; the frame is discarded with frame_err.
- Reset:
  - All gains go to GAIN_RESET; wr_stb, frame_err and spi_miso go to 0; wr_addr goes to 0; FSM goes to IDLE.
  - Reset asserted mid-frame aborts the frame with no write and no frame_err.
  - After reset, a frame already in progress on the pins is ignored until cs_n goes high and then low again.
- Back-to-back frames: a cs_n high time of at least 4 clk is sufficient; both frames commit.

Test Plan:
- Reset -> gain_1..gain_10 all = 13'd4096; spi_miso = 0; wr_stb = 0; frame_err = 0.
- Write frame 24'h18_0ABC (rw=0, addr=3, data=13'h0ABC) -> gain_4 = 13'h0ABC 4 clk after cs_n rises; wr_stb pulses for 1 clk with wr_addr = 3; all other gains unchanged.
- Write 13'h1FFF to addr 9, then read frame rw=1, addr=9 -> MISO bits 12..0 = 1_1111_1111_1111; gain_10 unchanged by the read.
- Write to addr 12 with data 13'h0123 -> no gain changes, no wr_stb, no frame_err; a read of addr 12 returns 13'd0 on MISO.
- cs_n deasserted after 17 bits, and a separate 25-bit frame -> frame_err pulses once per frame; all gains stay at their previous values.
- rst asserted after bit 10 of a write to addr 0 -> gain_1 = 13'd4096, no wr_stb; a following complete write to addr 0 with 13'h0001 sets gain_1 = 13'h0001.
